// File: rtl/booth_product_reg.sv
`default_nettype none
// ============================================================================
// Module   : booth_product_reg
// Purpose  : Product/multiplier register for an iterative Booth multiplier.
//            It holds {hi[H-1:0], lo[WIDTH-1:0], g}. On start, lo is loaded
//            with the multiplier and hi/g are cleared. Each accepted step
//            takes the ALU result for the upper field and arithmetic-shifts
//            the whole word right by SHIFT. After WIDTH/SHIFT steps the
//            signed product sits in P[2*WIDTH:1].
//            SHIFT=1 gives radix-2 Booth and SHIFT=2 gives radix-4 Booth.
// Ports    : clock, reset   - rising-edge clock, synchronous active-high reset
//            start          - load multiplier and begin (wins over step)
//            multiplier     - two's-complement multiplier, sampled on start
//            step_en, sum   - ALU result valid / new upper field
//            hi_out         - current upper field, operand to the ALU
//            booth_bits     - P[SHIFT:0], Booth recoding window
//            count          - steps completed since start
//            busy, done     - status (done held until next start/reset)
//            out_enable,out - tri-state result bus carrying P[2*WIDTH:1]
// Revision : 1.0 - initial release
// ============================================================================
module booth_product_reg #(
    parameter int WIDTH = 32,
    parameter int SHIFT = 2
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [WIDTH-1:0]                      multiplier,
    input  logic                                  step_en,
    input  logic [WIDTH+1:0]                      sum,
    output logic [WIDTH+1:0]                      hi_out,
    output logic [SHIFT:0]                        booth_bits,
    output logic [$clog2(WIDTH/SHIFT+1)-1:0]      count,
    output logic                                  busy,
    output logic                                  done,
    input  logic                                  out_enable,
    output logic [2*WIDTH-1:0]                    out
);

    localparam int H  = WIDTH + 2;
    localparam int P  = H + WIDTH + 1;
    localparam int N  = WIDTH / SHIFT;
    localparam int CW = $clog2(N + 1);

    localparam logic [1:0]    c_ST_IDLE = 2'd0;
    localparam logic [1:0]    c_ST_RUN  = 2'd1;
    localparam logic [1:0]    c_ST_DONE = 2'd2;
    localparam logic [CW-1:0] c_LAST    = CW'(N - 1);
    localparam logic [CW-1:0] c_ONE     = CW'(1);

    logic [P-1:0]        r_p;
    logic [CW-1:0]       r_count;
    logic [1:0]          r_state;

    // The step result replaces the upper field before the shift, so the
    // shift source is the ALU sum concatenated with the current lo and g.
    logic signed [P-1:0] w_src;
    logic [P-1:0]        w_shifted;

    assign w_src     = {sum, r_p[WIDTH:0]};
    assign w_shifted = w_src >>> SHIFT;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_p     <= '0;
            r_count <= '0;
            r_state <= c_ST_IDLE;
        end else if (start) begin
            r_p     <= {{H{1'b0}}, multiplier, 1'b0};
            r_count <= '0;
            r_state <= c_ST_RUN;
        end else if ((r_state == c_ST_RUN) && step_en) begin
            r_p     <= w_shifted;
            r_count <= r_count + c_ONE;
            if (r_count == c_LAST) begin
                r_state <= c_ST_DONE;
            end
        end
    end

    assign hi_out     = r_p[P-1:WIDTH+1];
    assign booth_bits = r_p[SHIFT:0];
    assign count      = r_count;
    assign busy       = (r_state == c_ST_RUN);
    assign done       = (r_state == c_ST_DONE);

    // Not gated by done: the bus owner only enables it once done is high.
    assign out = out_enable ? r_p[2*WIDTH:1] : {(2*WIDTH){1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_booth_product_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_product_reg
// Purpose  : Directed bench for booth_product_reg. One radix-4 32-bit
//            instance and one radix-2 8-bit instance, each fed by a small
//            Booth ALU model built from the DUT's hi_out/booth_bits.
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_product_reg;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- radix-4, WIDTH=32 instance ----------------
    logic               reset = 1'b1;
    logic               start4 = 1'b0;
    logic [31:0]        mult4 = '0;
    logic               step4 = 1'b0;
    logic [33:0]        sum4;
    logic [33:0]        hi4;
    logic [2:0]         bb4;
    logic [4:0]         cnt4;
    logic               busy4, done4;
    logic               oe4 = 1'b0;
    wire  [63:0]        out4;
    logic signed [31:0] mc4 = '0;
    logic signed [33:0] m4;
    logic signed [33:0] hs4;

    booth_product_reg #(.WIDTH(32), .SHIFT(2)) u_dut4 (
        .clock(clock), .reset(reset), .start(start4), .multiplier(mult4),
        .step_en(step4), .sum(sum4), .hi_out(hi4), .booth_bits(bb4),
        .count(cnt4), .busy(busy4), .done(done4),
        .out_enable(oe4), .out(out4)
    );

    assign m4  = mc4;
    assign hs4 = hi4;

    always_comb begin
        sum4 = hs4;
        case (bb4)
            3'b001, 3'b010: sum4 = hs4 + m4;
            3'b011:         sum4 = hs4 + (m4 <<< 1);
            3'b100:         sum4 = hs4 - (m4 <<< 1);
            3'b101, 3'b110: sum4 = hs4 - m4;
            default:        sum4 = hs4;
        endcase
    end

    // ---------------- radix-2, WIDTH=8 instance ----------------
    logic              start2 = 1'b0;
    logic [7:0]        mult2 = '0;
    logic              step2 = 1'b0;
    logic [9:0]        sum2;
    logic [9:0]        hi2;
    logic [1:0]        bb2;
    logic [3:0]        cnt2;
    logic              busy2, done2;
    logic              oe2 = 1'b0;
    wire  [15:0]       out2;
    logic signed [7:0] mc2 = '0;
    logic signed [9:0] m2;
    logic signed [9:0] hs2;

    booth_product_reg #(.WIDTH(8), .SHIFT(1)) u_dut2 (
        .clock(clock), .reset(reset), .start(start2), .multiplier(mult2),
        .step_en(step2), .sum(sum2), .hi_out(hi2), .booth_bits(bb2),
        .count(cnt2), .busy(busy2), .done(done2),
        .out_enable(oe2), .out(out2)
    );

    assign m2  = mc2;
    assign hs2 = hi2;

    always_comb begin
        sum2 = hs2;
        case (bb2)
            2'b01:   sum2 = hs2 + m2;
            2'b10:   sum2 = hs2 - m2;
            default: sum2 = hs2;
        endcase
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_r4(input logic [31:0] mcand, input logic [31:0] mult);
        mc4    = mcand;
        mult4  = mult;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
    endtask

    // n accepted steps, each preceded by gap idle cycles; idle cycles must hold state
    task automatic steps_r4(input int n, input int gap);
        logic [33:0] hi_before;
        logic [4:0]  cnt_before;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < gap; j++) begin
                hi_before  = hi4;
                cnt_before = cnt4;
                step4 = 1'b0;
                tick();
                chk("stall_count_hold", 64'(cnt4), 64'(cnt_before));
                chk("stall_hi_hold", 64'(hi4), 64'(hi_before));
                chk("stall_busy", 64'(busy4), 64'd1);
            end
            step4 = 1'b1;
            tick();
            step4 = 1'b0;
        end
    endtask

    initial begin
        // ---- reset and bus release ----
        tick();
        tick();
        chk("rst_busy", 64'(busy4), 64'd0);
        chk("rst_done", 64'(done4), 64'd0);
        chk("rst_count", 64'(cnt4), 64'd0);
        chk("rst_hi", 64'(hi4), 64'd0);
        chk("rst_booth_bits", 64'(bb4), 64'd0);
        n_checks++;
        assert (out4 === {64{1'bz}}) else begin
            n_fail++;
            $error("FAIL rst_out_z: observed %h expected all z", out4);
        end
        oe4 = 1'b1;
        #1;
        chk("rst_out_enabled", out4, 64'h0);
        oe4 = 1'b0;
        reset = 1'b0;
        tick();

        // ---- radix-4: 7 x -3, continuous stepping ----
        start_r4(32'd7, 32'hFFFF_FFFD);
        chk("load_busy", 64'(busy4), 64'd1);
        chk("load_count", 64'(cnt4), 64'd0);
        oe4 = 1'b1;
        #1;
        chk("load_lo", out4, 64'h0000_0000_FFFF_FFFD);
        oe4 = 1'b0;
        steps_r4(15, 0);
        chk("step15_done", 64'(done4), 64'd0);
        chk("step15_count", 64'(cnt4), 64'd15);
        steps_r4(1, 0);
        chk("p1_done", 64'(done4), 64'd1);
        chk("p1_busy", 64'(busy4), 64'd0);
        chk("p1_count", 64'(cnt4), 64'd16);
        oe4 = 1'b1;
        #1;
        chk("p1_product", out4, 64'hFFFF_FFFF_FFFF_FFEB);
        // step_en after done is ignored
        steps_r4(3, 0);
        chk("post_done_count", 64'(cnt4), 64'd16);
        chk("post_done_product", out4, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("post_done_done", 64'(done4), 64'd1);
        oe4 = 1'b0;

        // ---- stalled stepping, same operands ----
        start_r4(32'd7, 32'hFFFF_FFFD);
        steps_r4(16, 2);
        chk("stall_done", 64'(done4), 64'd1);
        chk("stall_final_count", 64'(cnt4), 64'd16);
        oe4 = 1'b1;
        #1;
        chk("stall_product", out4, 64'hFFFF_FFFF_FFFF_FFEB);
        oe4 = 1'b0;

        // ---- restart mid-run, then -1 x -1 ----
        start_r4(32'h7FFF_FFFF, 32'h8000_0000);
        steps_r4(5, 0);
        chk("partial_count", 64'(cnt4), 64'd5);
        start_r4(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("restart_count", 64'(cnt4), 64'd0);
        chk("restart_busy", 64'(busy4), 64'd1);
        steps_r4(16, 0);
        chk("m1_done", 64'(done4), 64'd1);
        oe4 = 1'b1;
        #1;
        chk("m1_product", out4, 64'h1);
        oe4 = 1'b0;

        // ---- start on the same edge as the final step ----
        start_r4(32'd7, 32'hFFFF_FFFD);
        steps_r4(15, 0);
        mc4    = 32'h8000_0000;
        mult4  = 32'h8000_0000;
        step4  = 1'b1;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        step4  = 1'b0;
        chk("collide_done", 64'(done4), 64'd0);
        chk("collide_busy", 64'(busy4), 64'd1);
        chk("collide_count", 64'(cnt4), 64'd0);
        steps_r4(16, 0);
        oe4 = 1'b1;
        #1;
        chk("min_sq_product", out4, 64'h4000_0000_0000_0000);
        oe4 = 1'b0;

        // ---- reset at step 9 ----
        start_r4(32'd7, 32'hFFFF_FFFD);
        steps_r4(8, 0);
        step4 = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        step4 = 1'b0;
        chk("midrst_busy", 64'(busy4), 64'd0);
        chk("midrst_done", 64'(done4), 64'd0);
        chk("midrst_count", 64'(cnt4), 64'd0);
        chk("midrst_hi", 64'(hi4), 64'd0);
        steps_r4(3, 0);
        chk("idle_step_count", 64'(cnt4), 64'd0);
        chk("idle_step_busy", 64'(busy4), 64'd0);

        // ---- radix-2, WIDTH=8: -128 x -128 then 5 x 0 ----
        mc2    = 8'sh80;
        mult2  = 8'h80;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        step2  = 1'b1;
        repeat (7) tick();
        chk("r2_step7_done", 64'(done2), 64'd0);
        tick();
        step2 = 1'b0;
        chk("r2_done", 64'(done2), 64'd1);
        chk("r2_count", 64'(cnt2), 64'd8);
        oe2 = 1'b1;
        #1;
        chk("r2_product", 64'(out2), 64'h4000);
        mc2    = 8'sd5;
        mult2  = 8'h00;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        step2  = 1'b1;
        repeat (8) tick();
        step2 = 1'b0;
        chk("r2_zero_done", 64'(done2), 64'd1);
        chk("r2_zero_product", 64'(out2), 64'h0000);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/booth_product_reg.md
# booth_product_reg

Parametrised product/multiplier register for the iterative multiplier datapath. It holds a combined {upper accumulator, multiplier, Booth guard bit} word. It supports radix-2 or radix-4 Booth stepping with an internal step counter and busy/done status, and drives the final product onto a shared result bus through tri-state outputs. An external adder/ALU supplies each partial sum.

## Interface
- WIDTH, 32, operand width in bits; even, ≥ 4
- SHIFT, 2, bits retired per step: 1 = radix-2 Booth, 2 = radix-4 Booth; WIDTH % SHIFT == 0
- Derived: H = WIDTH+2 (upper field), P = H+WIDTH+1 (register width), N = WIDTH/SHIFT (step count), CW = $clog2(N+1)

- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  load multiplier, begin operation
- multiplier  in  WIDTH  two's-complement multiplier, sampled on start
- step_en  in  1  ALU result valid this cycle; perform one Booth step
- sum  in  H  ALU result (new upper field) for the current step
- hi_out  out  H  current upper field, operand to ALU
- booth_bits  out  SHIFT+1  P[SHIFT:0], Booth recoding window for the ALU
- count  out  CW  steps completed since start
- busy  out  1  operation in progress
- done  out  1  product valid; level, held until next start/reset
- out_enable  in  1  result bus drive enable
- out  out  2*WIDTH  P[2*WIDTH:1] when out_enable=1, else all z

## Operation
- Register fields: P_reg = {hi[H-1:0], lo[WIDTH-1:0], g}.
- Priority per edge: reset > start > step.
- reset: P_reg=0, count=0, busy=0, done=0.
- start (any state, including busy): P_reg = {H'b0, multiplier, 1'b0}; count=0; busy=1; done=0.
- Step (busy & step_en & !start): P_reg = arithmetic shift right by SHIFT of {sum, lo, g}, replicating sum[H-1]. count increments.
  - When the accepted step is step N (count was N-1): busy=0, done=1, same edge.
- step_en while !busy: ignored, no state change, count holds.
- step_en low while busy: full hold, including count.
- States: IDLE (busy=0, done=0), RUN (busy=1), DONE (busy=0, done=1).
  - IDLE -start-> RUN; RUN -step N-> DONE; DONE -start-> RUN; any -reset-> IDLE.
- Arithmetic: all fields two's complement. H = WIDTH+2 absorbs ±2·multiplicand with no overflow.
  - After N steps, the signed 2W-bit product is exactly P_reg[2*WIDTH:1]. No wider product is represented.
- Output bus:
  - out is combinational from P_reg and out_enable. It is not gated by done.
  - The bus owner asserts out_enable only when done=1.
- hi_out, booth_bits, count, busy and done are combinational from registered state: no input-to-output paths.

## Timing
- Reset values: hi_out=0, booth_bits=0, count=0, busy=0, done=0; out = 0 if out_enable else z.
- start at edge k → busy=1 and lo=multiplier visible after edge k.
- With step_en held high from the cycle after start, done rises after edge k+N. For WIDTH=32, SHIFT=2 that is 16 cycles after load.
- sum must be valid in the same cycle as step_en. It is computed from hi_out/booth_bits of that cycle (single-cycle ALU path).
- start asserted on the same edge as the final step: start wins, and done stays 0.
- reset mid-RUN: IDLE on that edge; the next cycle behaves as post-reset.
- out_enable change: out switches combinationally the same cycle.

## Test plan
- Reset and bus release: assert reset 2 cycles, out_enable=0 → busy=0, done=0, count=0, out all z. Then out_enable=1 → out=0.
- Radix-4, WIDTH=32: multiplicand 7, multiplier −3, bench models the Booth ALU, step_en high continuously → done after exactly 16 steps, count=16, out=64'hFFFF_FFFF_FFFF_FFEB.
- Stalled stepping: same operands, step_en asserted every third cycle → count and P_reg hold on idle cycles; same product after 16 accepted steps; busy high throughout.
- Restart and extremes: start (0x7FFF_FFFF × 0x8000_0000) and stop after 5 steps; then start (−1 × −1) → count back to 0, done after 16 more steps, out=64'h1. Separately, 0x8000_0000 × 0x8000_0000 → out=64'h4000_0000_0000_0000.
- Reset mid-operation: reset asserted at step 9 → next cycle busy=0, done=0, count=0, hi_out=0. Later step_en pulses are ignored.
- Radix-2 instance (WIDTH=8, SHIFT=1): −128 × −128 → done after 8 steps, out=16'h4000. Then 5 × 0 → out=16'h0000.
